// File: rtl/branch_predictor.sv
// Branch history table of 2-bit saturating counters indexed by low PC bits.
// Optional perf counters (br_count, mispred_count) under BP_PERF_COUNTERS_EN.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 4,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        predict,
  input  logic [31:0] x_pc,
  input  logic [2:0]  result,
  input  logic        stall,
`ifdef BP_PERF_COUNTERS_EN
  output logic [31:0] br_count,
  output logic [31:0] mispred_count,
`endif
  output logic        mispredict
);

  localparam int unsigned DEPTH = 2 ** IDX_BITS;

  logic [1:0]          r_table [DEPTH];
  logic [IDX_BITS-1:0] w_rd_idx;
  logic [IDX_BITS-1:0] w_wr_idx;
  logic                w_taken;
  logic                w_upd;
  logic [1:0]          w_cur;
  logic [1:0]          w_next;
  logic                w_unused_pc;

  assign w_rd_idx = fetch_pc[IDX_BITS+1:2];
  assign w_wr_idx = x_pc[IDX_BITS+1:2];

  // Untagged table: upper PC bits and byte offset never take part in lookup.
  assign w_unused_pc = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0],
                         x_pc[31:IDX_BITS+2], x_pc[1:0]};

  // A correct prediction repeats predict_was; an incorrect one inverts it.
  assign w_taken    = ~(result[1] ^ result[0]);
  assign w_upd      = result[2] & ~stall & ~rst;
  assign mispredict = result[2] & ~result[0];

  // No bypass: a same-cycle write to rd_idx shows up next cycle.
  assign predict = r_table[w_rd_idx][1];

  always_comb begin
    w_cur  = r_table[w_wr_idx];
    w_next = w_cur;
    if (w_taken) begin
      if (w_cur != 2'b11) w_next = w_cur + 2'd1;
    end else begin
      if (w_cur != 2'b00) w_next = w_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_table[IDX_BITS'(i)] <= CNT_INIT;
      end
    end else if (w_upd) begin
      r_table[w_wr_idx] <= w_next;
    end
  end

`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_count      <= 32'd0;
      r_mispred_count <= 32'd0;
    end else if (w_upd) begin
      r_br_count <= r_br_count + 32'd1;
      if (!result[0]) r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;
`else
  // Perf counters not built.
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        predict;
  logic [31:0] x_pc;
  logic [2:0]  result;
  logic        stall;
  logic        mispredict;
`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] br_count;
  logic [31:0] mispred_count;
`endif

  int errors = 0;
  int checks = 0;

  branch_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_pc      (fetch_pc),
    .predict       (predict),
    .x_pc          (x_pc),
    .result        (result),
    .stall         (stall),
`ifdef BP_PERF_COUNTERS_EN
    .br_count      (br_count),
    .mispred_count (mispred_count),
`endif
    .mispredict    (mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; x_pc = 32'h0; fetch_pc = 32'h0; result = 3'b100;
    step();
    #1;
    checks++;
    if (mispredict !== 1'b1) begin
      errors++; $display("FAIL reset_mispredict_ungated got=%b exp=1", mispredict);
    end
    step();
    rst = 1'b0; result = 3'b000;
    #1;
    checks++;
    if (mispredict !== 1'b0) begin
      errors++; $display("FAIL reset_mispredict_idle got=%b exp=0", mispredict);
    end
    for (int i = 0; i < 16; i++) begin
      fetch_pc = 32'(i * 4);
      #1;
      checks++;
      if (predict !== 1'b0) begin
        errors++; $display("FAIL reset_sweep pc=%h got=%b exp=0", fetch_pc, predict);
      end
    end
`ifdef BP_PERF_COUNTERS_EN
    checks++;
    if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
      errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", br_count, mispred_count);
    end
`endif
    step();
  endtask

  task automatic test_mispredict();
    x_pc = 32'h08; fetch_pc = 32'h08; result = 3'b100;
    #1;
    checks++;
    if (mispredict !== 1'b1) begin
      errors++; $display("FAIL mispred_flag got=%b exp=1", mispredict);
    end
    checks++;
    if (predict !== 1'b0) begin
      errors++; $display("FAIL mispred_pre got=%b exp=0", predict);
    end
    step();
    result = 3'b000;
    #1;
    checks++;
    if (predict !== 1'b1) begin
      errors++; $display("FAIL mispred_post got=%b exp=1", predict);
    end
  endtask

  task automatic test_saturate();
    logic exp_dn [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    x_pc = 32'h10; fetch_pc = 32'h10; result = 3'b111;
    repeat (5) begin
      #1;
      checks++;
      if (mispredict !== 1'b0) begin
        errors++; $display("FAIL sat_taken_mispred got=%b exp=0", mispredict);
      end
      step();
    end
    result = 3'b000;
    #1;
    checks++;
    if (predict !== 1'b1) begin
      errors++; $display("FAIL sat_high got=%b exp=1", predict);
    end
    // 11 -> 10 -> 01 -> 00 -> 00 (stuck at floor)
    for (int k = 0; k < 4; k++) begin
      result = 3'b110;
      #1;
      checks++;
      if (mispredict !== 1'b1) begin
        errors++; $display("FAIL sat_nt_mispred step=%0d got=%b exp=1", k, mispredict);
      end
      step();
      result = 3'b000;
      #1;
      checks++;
      if (predict !== exp_dn[k]) begin
        errors++; $display("FAIL sat_down step=%0d got=%b exp=%b", k, predict, exp_dn[k]);
      end
    end
    result = 3'b111;
    step();
    result = 3'b000;
    #1;
    checks++;
    if (predict !== 1'b0) begin
      errors++; $display("FAIL sat_floor_up1 got=%b exp=0", predict);
    end
    result = 3'b111;
    step();
    result = 3'b000;
    #1;
    checks++;
    if (predict !== 1'b1) begin
      errors++; $display("FAIL sat_floor_up2 got=%b exp=1", predict);
    end
  endtask

  task automatic test_non_branch();
    x_pc = 32'h04; fetch_pc = 32'h04; result = 3'b011;
    repeat (3) begin
      #1;
      checks++;
      if (mispredict !== 1'b0 || predict !== 1'b0) begin
        errors++; $display("FAIL nonbr_hold got=%b%b exp=00", mispredict, predict);
      end
      step();
    end
    result = 3'b111;
    step();
    result = 3'b000;
    #1;
    checks++;
    if (predict !== 1'b1) begin
      errors++; $display("FAIL nonbr_then_taken got=%b exp=1", predict);
    end
  endtask

  task automatic test_stall();
    rst = 1'b1; result = 3'b000;
    step();
    rst = 1'b0;
    x_pc = 32'h0C; fetch_pc = 32'h0C; result = 3'b100; stall = 1'b1;
    repeat (3) begin
      #1;
      checks++;
      if (predict !== 1'b0) begin
        errors++; $display("FAIL stall_hold got=%b exp=0", predict);
      end
      step();
    end
    stall = 1'b0;
    step();
    result = 3'b000;
    #1;
    checks++;
    if (predict !== 1'b1) begin
      errors++; $display("FAIL stall_release got=%b exp=1", predict);
    end
`ifdef BP_PERF_COUNTERS_EN
    checks++;
    if (br_count !== 32'd1 || mispred_count !== 32'd1) begin
      errors++; $display("FAIL stall_perf got=%0d/%0d exp=1/1", br_count, mispred_count);
    end
`endif
    // Correct not-taken: 10 -> 01 only if a single increment happened.
    result = 3'b101;
    step();
    result = 3'b000;
    #1;
    checks++;
    if (predict !== 1'b0) begin
      errors++; $display("FAIL stall_single_inc got=%b exp=0", predict);
    end
`ifdef BP_PERF_COUNTERS_EN
    checks++;
    if (br_count !== 32'd2 || mispred_count !== 32'd1) begin
      errors++; $display("FAIL stall_perf2 got=%0d/%0d exp=2/1", br_count, mispred_count);
    end
`endif
  endtask

  task automatic test_collision();
    x_pc = 32'h14; fetch_pc = 32'h14; result = 3'b111;
    #1;
    checks++;
    if (predict !== 1'b0) begin
      errors++; $display("FAIL collide_same got=%b exp=0", predict);
    end
    step();
    result = 3'b000;
    #1;
    checks++;
    if (predict !== 1'b1) begin
      errors++; $display("FAIL collide_next got=%b exp=1", predict);
    end
  endtask

  task automatic test_reset_update();
    rst = 1'b1; x_pc = 32'h14; fetch_pc = 32'h14; result = 3'b111;
    step();
    rst = 1'b0; result = 3'b000;
    #1;
    checks++;
    if (predict !== 1'b0) begin
      errors++; $display("FAIL rst_upd_entry got=%b exp=0", predict);
    end
`ifdef BP_PERF_COUNTERS_EN
    checks++;
    if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
      errors++; $display("FAIL rst_upd_perf got=%0d/%0d exp=0/0", br_count, mispred_count);
    end
`endif
    result = 3'b111;
    step();
    result = 3'b000;
    fetch_pc = 32'h54;
    #1;
    checks++;
    if (predict !== 1'b1) begin
      errors++; $display("FAIL alias_high got=%b exp=1", predict);
    end
    fetch_pc = 32'h17;
    #1;
    checks++;
    if (predict !== 1'b1) begin
      errors++; $display("FAIL alias_low got=%b exp=1", predict);
    end
    fetch_pc = 32'h18;
    #1;
    checks++;
    if (predict !== 1'b0) begin
      errors++; $display("FAIL neighbour got=%b exp=0", predict);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; fetch_pc = 32'h0; x_pc = 32'h0; result = 3'b000;
    test_reset();
    test_mispredict();
    step();
    test_saturate();
    step();
    test_non_branch();
    step();
    test_stall();
    step();
    test_collision();
    step();
    test_reset_update();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
